sync_edge_counter: RTL and testbench
====================================

// Module: sync_edge_counter
// PURPOSE
//   Consumes the q output of an upstream _dff_r-style register stage, or any async 1-bit source.
//   Re-times the input through a reset-able flip-flop synchronizer chain.
//   Produces one-cycle rising/falling edge pulses and a CNT_W-bit edge event counter with overflow flag.
//   Sits between raw flip-flop outputs and control logic needing clean single-cycle events.
// PARAMETERS
//   SYNC_STAGES  2  synchronizer depth, legal range >= 2
//   CNT_W        8  counter width, legal range >= 2
//   EDGE_MODE    0  edges counted: 0 = rising, 1 = falling, 2 = both
// PORTS
//   clk         in   1      single clock; all flops on rising edge
//   reset_n     in   1      asynchronous, active-low reset
//   d           in   1      async data input (upstream q)
//   en          in   1      count enable, sync
//   clr         in   1      synchronous clear of count/overflow
//   q_sync      out  1      synchronized d
//   rise_pulse  out  1      1-cycle pulse on synchronized 0->1
//   fall_pulse  out  1      1-cycle pulse on synchronized 1->0
//   count       out  CNT_W  edge event count
//   overflow    out  1      sticky overflow flag
// BEHAVIOUR
//   Reset (reset_n=0, async, any time incl. mid-count): all flops clear immediately.
//     Flops: sync chain s[0..N-1], prev, count, overflow.
//     Outputs: q_sync=0, rise_pulse=0, fall_pulse=0, count=0, overflow=0.
//     Pulses deassert without waiting for clk.
//   Synchronizer: s[0]<=d; s[i]<=s[i-1]; q_sync=s[N-1].
//     d stable before edge k -> q_sync valid after edge k+N-1, i.e. N-edge latency.
//   prev<=q_sync every cycle.
//     rise_pulse = q_sync & ~prev; fall_pulse = ~q_sync & prev.
//     Decoded from flops only, glitch-free.
//     Each pulse lasts exactly 1 cycle per synchronized transition, never both at once.
//   Event: inc = en & (EDGE_MODE==0 ? rise_pulse : EDGE_MODE==1 ? fall_pulse : rise|fall).
//   Counter update at next rising clk, priority high->low:
//     1. clr=1 -> count<=0, overflow<=0 (clr wins over simultaneous inc).
//     2. inc=1 and count<max -> count<=count+1.
//     3. inc=1 and count==max -> wrap/saturate per CONFIGURATION.
//     4. else hold.
//   en=0: pulses still generated; count holds.
//   Pulses wider than 1 cycle on d are counted once; pulses shorter than 1 clk may be missed.
//   This is a defined limitation, not an error.
//   After reset release: chain refills from d.
//     d=1 at release -> rise_pulse appears N cycles later, counted if enabled.
//   All arithmetic is unsigned CNT_W bits; max = 2^CNT_W-1.
// CONFIGURATION
//   Macro SEC_SATURATE_EN.
//   Defined: count at max holds at max on inc; overflow<=1 (sticky until clr/reset).
//   Undefined (default): count at max wraps to 0 on inc; overflow<=1 (sticky until clr/reset).
//   Synchronizer and pulse logic are identical in both builds.
// TESTING
//   Applies to the default build unless noted.
//   T1 reset:
//     Stimulus: reset_n=0 while d=1 and count!=0, asserted between clk edges.
//     Response: all outputs 0 immediately; after release with d=1, q_sync=1 after 2 edges.
//   T2 latency/pulse (N=2):
//     Stimulus: d 0->1 before edge 1.
//     Response: q_sync=1 after edge 2; rise_pulse=1 for only the edge2..edge3 cycle; count 0->1 at edge 3.
//   T3 EDGE_MODE=2, en=1:
//     Stimulus: d toggles every 10 clk, 6 toggles.
//     Response: 3 rise + 3 fall pulses; count==6; fall_pulse never coincides with rise_pulse.
//   T4 clr priority:
//     Stimulus: clr=1 in the same cycle as rise_pulse=1 with count=5.
//     Response: count=0, overflow=0 next cycle.
//     Stimulus: en=0 with 4 further rising edges.
//     Response: count stays 0.
//   T5 wrap (CNT_W=2):
//     Stimulus: 5 rising edges.
//     Response: count 1,2,3,0,1; overflow=1 from 4th edge until clr.
//   T6 SEC_SATURATE_EN (CNT_W=2):
//     Stimulus: 5 rising edges.
//     Response: count 1,2,3,3,3; overflow=1 from 4th edge; clr -> 0/0.

Source files
------------

// File: rtl/sync_edge_counter.sv
// sync_edge_counter: re-times an async 1-bit input, emits single-cycle edge pulses
// and counts selected edges. Define SEC_SATURATE_EN to saturate at max instead of wrapping.
module sync_edge_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d,
    input  logic             en,
    input  logic             clr,
    output logic             q_sync,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;
    logic                   edge_sel;
    logic                   inc;

    // Value taken by the counter on an accepted event.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c);
`ifdef SEC_SATURATE_EN
        return (c == CNT_MAX) ? c : c + 1'b1;
`else
        return (c == CNT_MAX) ? '0 : c + 1'b1;
`endif
    endfunction

    // Stage p0: synchronizer chain, d enters at bit 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
        end
    end

    assign q_sync = sync_p0[SYNC_STAGES-1];

    // Stage p1: previous synchronized value for edge decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_p1 <= 1'b0;
        end else begin
            prev_p1 <= q_sync;
        end
    end

    assign rise_pulse = q_sync & ~prev_p1;
    assign fall_pulse = ~q_sync & prev_p1;

    always_comb begin
        edge_sel = rise_pulse;
        if (EDGE_MODE == 1) begin
            edge_sel = fall_pulse;
        end else if (EDGE_MODE == 2) begin
            edge_sel = rise_pulse | fall_pulse;
        end
    end

    assign inc = en & edge_sel;

    // Stage p2: event counter, clr has priority over a coincident event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc) begin
            count <= next_count(count);
            if (count == CNT_MAX) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_edge_counter.sv
// Self-checking bench for sync_edge_counter: rising-edge/8-bit, both-edge/8-bit and
// rising-edge/2-bit instances share one stimulus stream.
module tb_sync_edge_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d, en, clr;

    logic       q_a, rise_a, fall_a, ov_a;
    logic [7:0] cnt_a;
    logic       q_b, rise_b, fall_b, ov_b;
    logic [7:0] cnt_b;
    logic       q_c, rise_c, fall_c, ov_c;
    logic [1:0] cnt_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync_edge_counter #(.SYNC_STAGES(2), .CNT_W(8), .EDGE_MODE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .d(d), .en(en), .clr(clr),
        .q_sync(q_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
        .count(cnt_a), .overflow(ov_a));

    sync_edge_counter #(.SYNC_STAGES(2), .CNT_W(8), .EDGE_MODE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .d(d), .en(en), .clr(clr),
        .q_sync(q_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .count(cnt_b), .overflow(ov_b));

    sync_edge_counter #(.SYNC_STAGES(2), .CNT_W(2), .EDGE_MODE(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .d(d), .en(en), .clr(clr),
        .q_sync(q_c), .rise_pulse(rise_c), .fall_pulse(fall_c),
        .count(cnt_c), .overflow(ov_c));

    typedef struct {
        logic       d, en, clr;
        logic       q, rise, fall;
        logic [7:0] cnt;
        logic       ov;
    } vec_t;

    vec_t tbl [15];
    vec_t sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One clean synchronized rising edge followed by return to 0 and full settle.
    task automatic one_rise();
        d = 1'b1;
        tick(3);
        d = 1'b0;
        tick(3);
    endtask

    initial begin
        vec_t e;
        int   nr, nf, nboth;
        logic [1:0] c_exp [5];
        logic       o_exp [5];

        //          d     en    clr   q     rise  fall  cnt  ov
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};

`ifdef SEC_SATURATE_EN
        c_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        c_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
        o_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Power-on reset
        reset_n = 1'b0;
        d = 1'b0; en = 1'b0; clr = 1'b0;
        tick(3);
        chk("por_q", q_a, 0);
        chk("por_cnt", cnt_a, 0);
        chk("por_ov", ov_a, 0);
        reset_n = 1'b1;
        en = 1'b1;
        tick(3);

        // Latency, pulse shape, en gating, clr-vs-inc from the vector table
        for (int i = 0; i < 15; i++) begin
            d = tbl[i].d; en = tbl[i].en; clr = tbl[i].clr;
            sbq.push_back(tbl[i]);
            tick(1);
            e = sbq.pop_front();
            chk($sformatf("vec%0d_q", i), q_a, e.q);
            chk($sformatf("vec%0d_rise", i), rise_a, e.rise);
            chk($sformatf("vec%0d_fall", i), fall_a, e.fall);
            chk($sformatf("vec%0d_cnt", i), cnt_a, e.cnt);
            chk($sformatf("vec%0d_ov", i), ov_a, e.ov);
        end
        d = 1'b0; en = 1'b1; clr = 1'b0;
        tick(3);

        // clr coincident with rise_pulse at count 5, then en=0 holds
        clr = 1'b1; tick(1); clr = 1'b0;
        repeat (5) one_rise();
        chk("t4_cnt5", cnt_a, 5);
        d = 1'b1;
        tick(2);
        chk("t4_rise_pre", rise_a, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("t4_clr_cnt", cnt_a, 0);
        chk("t4_clr_ov", ov_a, 0);
        d = 1'b0;
        tick(3);
        en = 1'b0;
        repeat (4) one_rise();
        chk("t4_en0_cnt", cnt_a, 0);
        en = 1'b1;

        // 2-bit counter wrap or saturate with sticky overflow
        clr = 1'b1; tick(1); clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d = 1'b1;
            tick(3);
            chk($sformatf("t5_cnt%0d", k), cnt_c, c_exp[k]);
            chk($sformatf("t5_ov%0d", k), ov_c, o_exp[k]);
            d = 1'b0;
            tick(3);
        end
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("t5_clr_cnt", cnt_c, 0);
        chk("t5_clr_ov", ov_c, 0);

        // Both-edge counting with d toggling every 10 clocks
        clr = 1'b1; tick(1); clr = 1'b0;
        nr = 0; nf = 0; nboth = 0;
        for (int t = 0; t < 6; t++) begin
            d = ~d;
            for (int j = 0; j < 10; j++) begin
                tick(1);
                if (rise_b) nr++;
                if (fall_b) nf++;
                if (rise_b && fall_b) nboth++;
            end
        end
        chk("t3_rise", nr, 3);
        chk("t3_fall", nf, 3);
        chk("t3_both", nboth, 0);
        chk("t3_cnt", cnt_b, 6);
        chk("t3_cnt_rise_only", cnt_a, 3);

        // Asynchronous reset mid-count with d=1, then refill
        d = 1'b1;
        tick(3);
        chk("t1_pre_cnt", cnt_a, 4);
        chk("t1_pre_q", q_a, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_q", q_a, 0);
        chk("t1_rise", rise_a, 0);
        chk("t1_fall", fall_a, 0);
        chk("t1_cnt_a", cnt_a, 0);
        chk("t1_ov_a", ov_a, 0);
        chk("t1_cnt_b", cnt_b, 0);
        chk("t1_q_c", q_c, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("t1_rel_e1_q", q_a, 0);
        tick(1);
        chk("t1_rel_e2_q", q_a, 1);
        chk("t1_rel_e2_rise", rise_a, 1);
        tick(1);
        chk("t1_rel_e3_rise", rise_a, 0);
        chk("t1_rel_e3_cnt", cnt_a, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
